reg_dump_streamer: RTL
======================

REG_DUMP_STREAMER -- requirements
Module: reg_dump_streamer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32: number of registers dumped, indices 0..NUM_REGS-1.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5: frame header byte.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request one dump frame; sampled only in IDLE.
REQ-006 SHALL have port reg_sel, output, 5 bits: register index to the CPU debug read port.
REQ-007 SHALL have port reg_data, input, 32 bits: register value returned combinationally for reg_sel.
REQ-008 SHALL have port out_data, output, 8 bits: stream byte.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: sink accepts the byte; transfer = out_valid & out_ready.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-013 SHALL use states IDLE, HDR, SEL, CAP, BYTE, CSUM and DONE.
REQ-014 Frame SHALL be SYNC_BYTE, then 4 bytes per register MSB first for registers 0..NUM_REGS-1 ascending, then one checksum byte; 130 bytes at the default.
REQ-015 Checksum SHALL be the XOR of all register bytes, excluding SYNC_BYTE.
REQ-016 IDLE with start=1 SHALL go to HDR next cycle; in HDR, out_valid=1 and out_data=SYNC_BYTE.
REQ-017 HDR transfer SHALL go to SEL with register index 0.
REQ-018 SEL SHALL drive reg_sel = index from a flop for one settle cycle, then go to CAP.
REQ-019 CAP SHALL latch reg_data into a 32-bit shift register, clear the byte count, then go to BYTE.
REQ-020 In BYTE, out_data SHALL be shift[31:24]; each transfer shifts left 8 and XORs the byte into the checksum.
REQ-021 The 4th transfer of a register SHALL go to SEL with index+1, or to CSUM if index = NUM_REGS-1.
REQ-022 In CSUM, out_valid=1 and out_data=checksum; the transfer SHALL go to DONE.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 With out_ready held 1, done SHALL go high 195 cycles after the start sample edge: 1 HDR + 32x(SEL+CAP+4 BYTE) + 1 CSUM + 1.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable; out_valid SHALL never drop without a transfer, except on reset.
REQ-026 out_valid SHALL be 0 in IDLE, SEL, CAP and DONE.
REQ-027 start SHALL be ignored while busy=1; start held high in IDLE right after DONE SHALL begin a new frame.
REQ-028 The checksum register SHALL clear on leaving IDLE.
REQ-029 reg_sel SHALL hold its last value outside SEL, CAP and BYTE.

Reset
REQ-030 rstn low SHALL immediately force: IDLE, out_valid=0, out_data=0, reg_sel=0, busy=0, done=0, index=0, checksum=0, shift=0.
REQ-031 Reset mid-frame SHALL abandon the frame; the next start SHALL restart from HDR.
REQ-032 Reset deassertion SHALL take effect at the next clk edge; no start is accepted in the cycle rstn rises.

Structure
REQ-033 Package reg_dump_pkg SHALL hold the state enum, default SYNC_BYTE, BYTES_PER_REG=4 and the index width.
REQ-034 Sub-module reg_dump_ser SHALL implement the 32-to-8 shift register, byte counter and checksum accumulation; the top holds the FSM.

Verification
REQ-035 Reset check: assert rstn=0 mid-run -> all outputs 0 within the same cycle, without a clock edge.
REQ-036 Single-value dump: reg1=32'h12345678, others 0, out_ready=1, pulse start -> 130 bytes; byte0=A5, bytes 5..8=12 34 56 78, final byte=08, done at start+195.
REQ-037 Backpressure: same dump, drop out_ready for 5 cycles on byte 6 (34) -> out_data=34 and out_valid=1 held all 5 cycles; full frame identical to REQ-036.
REQ-038 Ignored start: pulse start at byte 20 -> single frame of 130 bytes, exactly one done pulse.
REQ-039 Abort and restart: rstn low for 2 cycles after byte 40, then start -> out_valid drops at once; new frame is a full 130 bytes starting A5.
REQ-040 Per-register readout: reg_data = {24'h0, reg_sel} for all registers, with a reg_sel checker -> reg_sel steps 0..31 in order; register k bytes = 00 00 00 k; checksum 00.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg
// Shared definitions for the register dump streamer: FSM state encoding,
// default frame header byte, bytes per register, index/counter widths and
// the checksum accumulation helper.
package reg_dump_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned BYTES_PER_REG = 32'd4;
  localparam int unsigned IDX_W         = 32'd5;
  localparam int unsigned BYTE_CNT_W    = 32'd2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SEL  = 3'd2,
    CAP  = 3'd3,
    BYTE = 3'd4,
    CSUM = 3'd5,
    DONE = 3'd6
  } state_e;

  // One step of the frame checksum: running XOR of register bytes.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/reg_dump_ser.sv
// reg_dump_ser
// 32-to-8 serializer for one captured register word, with a byte counter
// and the running XOR checksum over every register byte sent.
// Ports:
//   clk, rstn   - clock, asynchronous active-low reset
//   clr         - clear checksum (frame start)
//   load        - capture load_data into the shift register, clear byte count
//   load_data   - 32-bit register word
//   shift_en    - current byte accepted: shift left 8, fold byte into checksum
//   next_byte   - byte that becomes current after the next shift
//   last_byte   - current byte is the last byte of this register
//   csum_next   - checksum including the current byte
module reg_dump_ser
  import reg_dump_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        shift_en,
  output logic [7:0]  next_byte,
  output logic        last_byte,
  output logic [7:0]  csum_next
);

  localparam logic [BYTE_CNT_W-1:0] CNT_ZERO = {BYTE_CNT_W{1'b0}};
  localparam logic [BYTE_CNT_W-1:0] CNT_ONE  = BYTE_CNT_W'(1'b1);
  localparam logic [BYTE_CNT_W-1:0] CNT_LAST = BYTE_CNT_W'(BYTES_PER_REG - 32'd1);

  logic [31:0]           shift_r;
  logic [BYTE_CNT_W-1:0] cnt_r;
  logic [7:0]            csum_r;

  // Shift register and byte counter: load on capture, advance on each accepted byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_r <= 32'd0;
      cnt_r   <= CNT_ZERO;
    end else if (load) begin
      shift_r <= load_data;
      cnt_r   <= CNT_ZERO;
    end else if (shift_en) begin
      shift_r <= {shift_r[23:0], 8'd0};
      cnt_r   <= cnt_r + CNT_ONE;
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

  // Running checksum: cleared at frame start, folds in each accepted register byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      csum_r <= 8'd0;
    end else if (clr) begin
      csum_r <= 8'd0;
    end else if (shift_en) begin
      csum_r <= csum_step(csum_r, shift_r[31:24]);
    end else begin
      csum_r <= csum_r;
    end
  end

  assign next_byte = shift_r[23:16];
  assign last_byte = (cnt_r == CNT_LAST);
  assign csum_next = csum_step(csum_r, shift_r[31:24]);

endmodule

// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer
// Streams a dump frame of CPU registers as bytes over a valid/ready link:
// SYNC_BYTE, then 4 bytes per register (MSB first, registers ascending),
// then the XOR checksum of all register bytes.
// Ports:
//   clk, rstn  - clock (rising edge), asynchronous active-low reset
//   start      - request a frame, sampled only in IDLE
//   reg_sel    - register index to the debug read port
//   reg_data   - register value for reg_sel (combinational return)
//   out_data   - stream byte; out_valid - byte valid; out_ready - sink ready
//   busy       - frame in progress (any state but IDLE)
//   done       - one-cycle pulse at frame end
// All stream/status outputs come straight from flops; their next values are
// computed from the next state so they line up with the state they describe.
module reg_dump_streamer
  import reg_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 32,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 32'd1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_nxt_s;
  logic [7:0]       out_data_r;
  logic [7:0]       data_nxt_s;
  logic             out_valid_r;
  logic             valid_nxt_s;
  logic             busy_r;
  logic             done_r;

  logic             xfer_s;
  logic             ser_clr_s;
  logic             ser_load_s;
  logic             ser_shift_s;
  logic [7:0]       next_byte_s;
  logic             last_byte_s;
  logic [7:0]       csum_next_s;

  assign xfer_s = out_valid_r & out_ready;

  reg_dump_ser u_ser (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (ser_clr_s),
    .load      (ser_load_s),
    .load_data (reg_data),
    .shift_en  (ser_shift_s),
    .next_byte (next_byte_s),
    .last_byte (last_byte_s),
    .csum_next (csum_next_s)
  );

  // Next-state, next index and next registered stream byte/valid.
  // out_valid only falls on a transfer, so a stalled byte stays put.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    data_nxt_s  = out_data_r;
    valid_nxt_s = 1'b0;
    ser_clr_s   = 1'b0;
    ser_load_s  = 1'b0;
    ser_shift_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = HDR;
          data_nxt_s  = SYNC_BYTE;
          valid_nxt_s = 1'b1;
          ser_clr_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HDR: begin
        if (xfer_s) begin
          state_nxt_s = SEL;
          idx_nxt_s   = IDX_ZERO;
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      SEL: begin
        // reg_sel has been stable for a cycle; capture next.
        state_nxt_s = CAP;
      end
      CAP: begin
        state_nxt_s = BYTE;
        ser_load_s  = 1'b1;
        data_nxt_s  = reg_data[31:24];
        valid_nxt_s = 1'b1;
      end
      BYTE: begin
        if (xfer_s) begin
          ser_shift_s = 1'b1;
          if (!last_byte_s) begin
            data_nxt_s  = next_byte_s;
            valid_nxt_s = 1'b1;
          end else if (idx_r == IDX_LAST) begin
            state_nxt_s = CSUM;
            data_nxt_s  = csum_next_s;
            valid_nxt_s = 1'b1;
          end else begin
            state_nxt_s = SEL;
            idx_nxt_s   = idx_r + IDX_ONE;
          end
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      CSUM: begin
        if (xfer_s) begin
          state_nxt_s = DONE;
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state, register index and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      idx_r       <= IDX_ZERO;
      out_data_r  <= 8'd0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      out_data_r  <= data_nxt_s;
      out_valid_r <= valid_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
      done_r      <= (state_nxt_s == DONE);
    end
  end

  assign reg_sel   = idx_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
